// File: rtl/pong_pkg.sv
// Shared state encodings, default geometry and derived screen constants for the pong engine.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_POINT     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam int SCREEN_W_DEF     = 640;
  localparam int SCREEN_H_DEF     = 480;
  localparam int PADDLE_W_DEF     = 8;
  localparam int PADDLE_H_DEF     = 50;
  localparam int BALL_SIZE_DEF    = 8;
  localparam int P1_X_DEF         = 40;
  localparam int P2_X_DEF         = 600;
  localparam int PADDLE_SPEED_DEF = 4;
  localparam int BALL_SPEED_DEF   = 2;
  localparam int SCORE_W_DEF      = 4;
  localparam int WIN_SCORE_DEF    = 9;
  localparam int PAUSE_FRAMES_DEF = 60;

  // Top-left coordinate that centres an object of 'size' within 'full'.
  function automatic int centre(input int full, input int size);
    return (full - size) / 2;
  endfunction

  localparam int BALL_CX_DEF     = centre(SCREEN_W_DEF, BALL_SIZE_DEF);
  localparam int BALL_CY_DEF     = centre(SCREEN_H_DEF, BALL_SIZE_DEF);
  localparam int PADDLE_CY_DEF   = centre(SCREEN_H_DEF, PADDLE_H_DEF);
  localparam int PADDLE_YMAX_DEF = SCREEN_H_DEF - PADDLE_H_DEF;
  localparam int BALL_XMAX_DEF   = SCREEN_W_DEF - BALL_SIZE_DEF;
  localparam int BALL_YMAX_DEF   = SCREEN_H_DEF - BALL_SIZE_DEF;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: per-frame up/down motion with clamping to the playfield and a re-centre request.
module paddle_ctrl #(
  parameter int Y_MAX  = 430,
  parameter int Y_INIT = 215,
  parameter int SPEED  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  input  logic       recentre,
  output logic [9:0] y
);

  localparam logic [9:0] YMAX_V  = 10'(Y_MAX);
  localparam logic [9:0] YINIT_V = 10'(Y_INIT);
  localparam logic [9:0] SPEED_V = 10'(SPEED);

  // Paddle position: re-centre wins, then exclusive up/down with saturation at both edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= YINIT_V;
    end else if (tick) begin
      if (recentre) begin
        y <= YINIT_V;
      end else if (en && up && !dn) begin
        y <= (y < SPEED_V) ? '0 : y - SPEED_V;
      end else if (en && dn && !up) begin
        y <= (y > YMAX_V - SPEED_V) ? YMAX_V : y + SPEED_V;
      end
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Frame-rate pong game state: paddles, ball physics, scoring and the serve/point/game-over FSM.
module pong_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int PADDLE_W     = PADDLE_W_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int P1_X         = P1_X_DEF,
  parameter int P2_X         = P2_X_DEF,
  parameter int PADDLE_SPEED = PADDLE_SPEED_DEF,
  parameter int BALL_SPEED   = BALL_SPEED_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p1_srv,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic               p2_srv,
  output logic [9:0]         p1_y,
  output logic [9:0]         p2_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         state,
  output logic               winner
);

  localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [9:0]          BALL_CX   = 10'(centre(SCREEN_W, BALL_SIZE));
  localparam logic [9:0]          BALL_CY   = 10'(centre(SCREEN_H, BALL_SIZE));
  localparam logic signed [10:0]  BSPEED_S  = 11'(BALL_SPEED);
  localparam logic signed [10:0]  XMAX_S    = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0]  YMAX_S    = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0]  P1_HIT_S  = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0]  P2_HIT_S  = 11'(P2_X - BALL_SIZE);
  localparam logic [10:0]         BSIZE_U   = 11'(BALL_SIZE);
  localparam logic [10:0]         PH_U      = 11'(PADDLE_H);
  localparam logic [SCORE_W-1:0]  WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;
  localparam logic [PW-1:0]       PAUSE_END = PW'(PAUSE_FRAMES - 1);

  state_t             st, st_n;
  logic [9:0]         ball_x_n, ball_y_n;
  logic [SCORE_W-1:0] p1_score_n, p2_score_n;
  logic               winner_n;
  logic               dx, dx_n;      // 1 = moving +x (right)
  logic               dy, dy_n;      // 1 = moving +y (down)
  logic               server, server_n;  // 0 = P1 serves
  logic [PW-1:0]      pause_cnt, pause_cnt_n;
  logic               recentre;
  logic               paddle_en;
  logic signed [10:0] bx_s, by_s, nx, ny;
  logic               ov1, ov2;

  assign state     = st;
  assign paddle_en = (st != ST_GAME_OVER);

  paddle_ctrl #(
    .Y_MAX (SCREEN_H - PADDLE_H),
    .Y_INIT(centre(SCREEN_H, PADDLE_H)),
    .SPEED (PADDLE_SPEED)
  ) u_paddle1 (
    .clk     (clk),
    .rst     (rst),
    .tick    (frame_tick),
    .en      (paddle_en),
    .up      (p1_up),
    .dn      (p1_dn),
    .recentre(recentre),
    .y       (p1_y)
  );

  paddle_ctrl #(
    .Y_MAX (SCREEN_H - PADDLE_H),
    .Y_INIT(centre(SCREEN_H, PADDLE_H)),
    .SPEED (PADDLE_SPEED)
  ) u_paddle2 (
    .clk     (clk),
    .rst     (rst),
    .tick    (frame_tick),
    .en      (paddle_en),
    .up      (p2_up),
    .dn      (p2_dn),
    .recentre(recentre),
    .y       (p2_y)
  );

  // Next game state: ball step, bounces, scoring and FSM transitions for one frame.
  always_comb begin
    st_n        = st;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    p1_score_n  = p1_score;
    p2_score_n  = p2_score;
    winner_n    = winner;
    dx_n        = dx;
    dy_n        = dy;
    server_n    = server;
    pause_cnt_n = pause_cnt;
    recentre    = 1'b0;

    bx_s = signed'({1'b0, ball_x});
    by_s = signed'({1'b0, ball_y});
    nx   = dx ? bx_s + BSPEED_S : bx_s - BSPEED_S;
    ny   = dy ? by_s + BSPEED_S : by_s - BSPEED_S;
    // Vertical overlap of the ball with each paddle, using pre-tick paddle positions.
    ov1  = ({1'b0, ball_y} + BSIZE_U > {1'b0, p1_y}) && ({1'b0, ball_y} < {1'b0, p1_y} + PH_U);
    ov2  = ({1'b0, ball_y} + BSIZE_U > {1'b0, p2_y}) && ({1'b0, ball_y} < {1'b0, p2_y} + PH_U);

    if (frame_tick) begin
      case (st)
        ST_SERVE: begin
          if (server ? p2_srv : p1_srv) begin
            st_n = ST_PLAY;
            dx_n = ~server;
            dy_n = 1'b1;
          end
        end
        ST_PLAY: begin
          if (ny <= 11'sd0) begin
            ball_y_n = '0;
            dy_n     = 1'b1;
          end else if (ny >= YMAX_S) begin
            ball_y_n = YMAX_S[9:0];
            dy_n     = 1'b0;
          end else begin
            ball_y_n = ny[9:0];
          end

          if (!dx) begin
            if (nx <= P1_HIT_S && bx_s >= P1_HIT_S && ov1) begin
              ball_x_n = P1_HIT_S[9:0];
              dx_n     = 1'b1;
            end else if (nx < 11'sd0) begin
              // Missed on the left: ball freezes where it was.
              ball_x_n   = ball_x;
              ball_y_n   = ball_y;
              dy_n       = dy;
              p2_score_n = (p2_score == SCORE_MAX) ? p2_score : p2_score + 1'b1;
              server_n   = 1'b0;
              st_n       = ST_POINT;
            end else begin
              ball_x_n = nx[9:0];
            end
          end else begin
            if (nx >= P2_HIT_S && bx_s <= P2_HIT_S && ov2) begin
              ball_x_n = P2_HIT_S[9:0];
              dx_n     = 1'b0;
            end else if (nx > XMAX_S) begin
              // Missed on the right: ball freezes where it was.
              ball_x_n   = ball_x;
              ball_y_n   = ball_y;
              dy_n       = dy;
              p1_score_n = (p1_score == SCORE_MAX) ? p1_score : p1_score + 1'b1;
              server_n   = 1'b1;
              st_n       = ST_POINT;
            end else begin
              ball_x_n = nx[9:0];
            end
          end
        end
        ST_POINT: begin
          if (pause_cnt == PAUSE_END) begin
            pause_cnt_n = '0;
            ball_x_n    = BALL_CX;
            ball_y_n    = BALL_CY;
            if (p1_score == WIN_V || p2_score == WIN_V) begin
              st_n     = ST_GAME_OVER;
              winner_n = (p2_score == WIN_V);
            end else begin
              st_n = ST_SERVE;
            end
          end else begin
            pause_cnt_n = pause_cnt + 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (p1_srv || p2_srv) begin
            p1_score_n = '0;
            p2_score_n = '0;
            recentre   = 1'b1;
            server_n   = ~winner;
            st_n       = ST_SERVE;
          end
        end
        default: st_n = ST_SERVE;
      endcase
    end
  end

  // Game state register; reset restores the serve position regardless of frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_SERVE;
      ball_x    <= BALL_CX;
      ball_y    <= BALL_CY;
      p1_score  <= '0;
      p2_score  <= '0;
      winner    <= 1'b0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      server    <= 1'b0;
      pause_cnt <= '0;
    end else begin
      st        <= st_n;
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      p1_score  <= p1_score_n;
      p2_score  <= p2_score_n;
      winner    <= winner_n;
      dx        <= dx_n;
      dy        <= dy_n;
      server    <= server_n;
      pause_cnt <= pause_cnt_n;
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: paddles, serve, walls, paddle bounces, scoring to game over, reset.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p1_srv = 1'b0;
  logic       p2_up = 1'b0, p2_dn = 1'b0, p2_srv = 1'b0;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;
  logic       winner;

  int n_vec = 0;
  int n_bad = 0;

  pong_engine dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .p1_up     (p1_up),
    .p1_dn     (p1_dn),
    .p1_srv    (p1_srv),
    .p2_up     (p2_up),
    .p2_dn     (p2_dn),
    .p2_srv    (p2_srv),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .state     (state),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // n frame ticks, each a one-cycle pulse followed by an idle cycle; returns at a negedge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(ball_x), 32'(x));
    chk({tag, "_y"}, 32'(ball_y), 32'(y));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p1y"}, 32'(p1_y), 32'd215);
    chk({tag, "_p2y"}, 32'(p2_y), 32'd215);
    chk_ball(tag, 316, 236);
    chk({tag, "_p1s"}, 32'(p1_score), 32'd0);
    chk({tag, "_p2s"}, 32'(p2_score), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_winner"}, 32'(winner), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst");
    tick(3);
    chk_reset_vals("idle3");

    // Paddles: p1 up to the top edge; p2 both pressed holds, then p2 down alone.
    p1_up = 1'b1; p2_up = 1'b1; p2_dn = 1'b1;
    tick(10);
    chk("p2_both_hold", 32'(p2_y), 32'd215);
    chk("p1_up10", 32'(p1_y), 32'd175);
    p2_up = 1'b0;
    tick(43);
    chk("p1_up53", 32'(p1_y), 32'd3);
    tick(1);
    chk("p1_up54", 32'(p1_y), 32'd0);
    tick(6);
    chk("p1_up60", 32'(p1_y), 32'd0);
    chk("p2_dn50", 32'(p2_y), 32'd415);
    p1_up = 1'b0; p2_dn = 1'b0;

    // Serve: non-server ignored, then P1 serves.
    p2_srv = 1'b1; tick(1); p2_srv = 1'b0;
    chk("p2srv_ignored", 32'(state), 32'd0);
    p1_srv = 1'b1; tick(1); p1_srv = 1'b0;
    chk("p1srv_play", 32'(state), 32'd1);
    chk_ball("serve_tick", 316, 236);
    tick(1);
    chk_ball("play1", 318, 238);
    tick(116);
    chk_ball("play117", 550, 470);
    tick(1);
    chk_ball("bottom_wall", 552, 472);
    tick(1);
    chk_ball("bottom_dy_neg", 554, 470);
    tick(18);
    chk_ball("play137", 590, 434);
    tick(1);
    chk_ball("p2_bounce", 592, 432);
    tick(1);
    chk_ball("p2_dx_neg", 590, 430);

    // Reset mid-play without a frame tick.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midplay_rst");

    // P1 paddle parked low, P2 parked at the top: P2 always misses, P1 always returns.
    p1_dn = 1'b1; p2_up = 1'b1;
    tick(60);
    chk("p1_park", 32'(p1_y), 32'd430);
    chk("p2_park", 32'(p2_y), 32'd0);
    p1_srv = 1'b1; tick(1); p1_srv = 1'b0;
    tick(158);
    chk("pre_miss_state", 32'(state), 32'd1);
    chk_ball("pre_miss", 632, 392);
    tick(1);
    chk("miss_state", 32'(state), 32'd2);
    chk("miss_p1s", 32'(p1_score), 32'd1);
    chk_ball("miss_frozen", 632, 392);
    tick(59);
    chk("pause59", 32'(state), 32'd2);
    tick(1);
    chk("pause60", 32'(state), 32'd0);
    chk_ball("recentred", 316, 236);

    for (int i = 2; i <= 9; i++) begin
      if (i == 2) begin
        p1_srv = 1'b1; tick(1); p1_srv = 1'b0;
        chk("p1srv_not_server", 32'(state), 32'd0);
      end
      p2_srv = 1'b1; tick(1); p2_srv = 1'b0;
      chk("p2_serve", 32'(state), 32'd1);
      if (i == 2) begin
        tick(134);
        chk_ball("p1_bounce", 48, 440);
        tick(219);
        chk_ball("top_approach", 486, 2);
        tick(1);
        chk_ball("top_wall", 488, 0);
        tick(1);
        chk_ball("top_dy_pos", 490, 2);
        tick(72);
      end else begin
        tick(427);
      end
      chk("rally_point", 32'(state), 32'd2);
      chk("rally_p1s", 32'(p1_score), 32'(i));
      chk("rally_p2s", 32'(p2_score), 32'd0);
      tick(60);
      chk("after_pause", 32'(state), (i < 9) ? 32'd0 : 32'd3);
    end

    chk("winner", 32'(winner), 32'd0);
    p1_dn = 1'b0; p1_up = 1'b1;
    tick(2);
    chk("go_frozen", 32'(p1_y), 32'd430);
    chk("go_hold", 32'(state), 32'd3);
    p2_srv = 1'b1; tick(1); p2_srv = 1'b0;
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_p1s", 32'(p1_score), 32'd0);
    chk("restart_p2s", 32'(p2_score), 32'd0);
    chk("restart_p1y", 32'(p1_y), 32'd215);
    chk("restart_p2y", 32'(p2_y), 32'd215);
    p1_srv = 1'b1; tick(1); p1_srv = 1'b0;
    chk("loser_serves", 32'(state), 32'd0);
    p2_srv = 1'b1; tick(1); p2_srv = 1'b0;
    chk("loser_served", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
